hack_imem_arbiter: RTL

Arbitrates the single-port instruction memory (on-board SRAM controller or generic RAM, both with 1-cycle read latency) between the Hack CPU fetch port and the UART host load/readback port. It replaces the combinational `wvalid`-based steering in the platform top: it halts the CPU cleanly, drains the in-flight fetch, grants the host exclusive access, and returns the memory to the CPU after a programmable idle period. It sits between `hack_cpu`, `uart_host` and the instruction memory.

---
 rtl/hack_pkg.sv | 19 +
 rtl/hack_imem_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hack_pkg.sv
// ----------------------------------------------------------------------------
// hack_pkg
// Shared declarations for the Hack platform blocks.
//   imem_arb_state_t     : ownership phases of the instruction-memory arbiter
//   IMEM_ARB_IDLE_CYCLES : default host-idle period before the CPU regains
//                          the instruction memory
// ----------------------------------------------------------------------------
package hack_pkg;

   typedef enum logic [1:0] {
      CPU     = 2'd0,
      DRAIN   = 2'd1,
      HOST    = 2'd2,
      RELEASE = 2'd3
   } imem_arb_state_t;

   localparam int IMEM_ARB_IDLE_CYCLES = 64;

endpackage

// File: rtl/hack_imem_arbiter.sv
// ----------------------------------------------------------------------------
// hack_imem_arbiter
// Shares the single-port instruction memory (1-cycle read latency) between
// the Hack CPU fetch port and the UART host load/readback port.  The CPU owns
// the memory by default; a host request freezes the CPU, one drain cycle lets
// the last fetch retire, then the host owns the memory until it has been idle
// for IDLE_CYCLES cycles, after which one release cycle hands it back.
//
// Ports
//   clk, rst_n         : clock, synchronous active-low reset
//   cpu_pc             : CPU fetch word address
//   cpu_instr(_valid)  : fetched instruction (mem_rdata passthrough) + valid
//   cpu_hold           : CPU must freeze PC and architectural state
//   host_address       : host byte address (bit 0 ignored)
//   host_wvalid/wready/wdata : host write channel
//   host_rvalid/rready : host read request channel
//   host_rrvalid/rdata : host read response
//   mem_*              : memory port
//   dbg_state          : current ownership phase, for observation only
//
// Handshake: a host write (read request) transfers in the cycle where
// host_wvalid & host_wready (host_rvalid & host_rready) are both high.  The
// host must hold valid and its payload stable until ready; ready may depend
// combinationally on valid, never the reverse.  A read response appears on
// host_rrvalid/host_rdata exactly one cycle after the accepting cycle and is
// not back-pressured.
// ----------------------------------------------------------------------------
module hack_imem_arbiter
   import hack_pkg::*;
#(
   parameter int AW          = 18,
   parameter int DW          = 16,
   parameter int PW          = 16,
   parameter int IDLE_CYCLES = IMEM_ARB_IDLE_CYCLES
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [PW-1:0]   cpu_pc,
   output logic [DW-1:0]   cpu_instr,
   output logic            cpu_instr_valid,
   output logic            cpu_hold,
   input  logic [15:0]     host_address,
   input  logic            host_wvalid,
   output logic            host_wready,
   input  logic [DW-1:0]   host_wdata,
   input  logic            host_rvalid,
   output logic            host_rready,
   output logic            host_rrvalid,
   output logic [DW-1:0]   host_rdata,
   output logic            mem_read,
   output logic            mem_write,
   output logic [AW-1:0]   mem_address,
   output logic [DW-1:0]   mem_wdata,
   input  logic [DW-1:0]   mem_rdata,
   output imem_arb_state_t dbg_state
);

   localparam logic [1:0] S_CPU     = CPU;
   localparam logic [1:0] S_DRAIN   = DRAIN;
   localparam logic [1:0] S_HOST    = HOST;
   localparam logic [1:0] S_RELEASE = RELEASE;

   localparam int            CW       = $clog2(IDLE_CYCLES + 1);
   localparam logic [CW-1:0] IDLE_LIM = CW'(IDLE_CYCLES);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] idle_cnt_q, idle_cnt_d;
   logic [CW-1:0] idle_cnt_inc;
   logic          instr_valid_q, instr_valid_d;
   logic          rrvalid_q, rrvalid_d;
   logic          host_req;
   logic [AW-1:0] cpu_addr;
   logic [AW-1:0] host_addr;
   logic          unused_addr_lsb;

   assign host_req        = host_wvalid | host_rvalid;
   assign cpu_addr        = AW'(cpu_pc);
   // Host addresses bytes; the memory holds 16-bit words.
   assign host_addr       = AW'(host_address[15:1]);
   assign unused_addr_lsb = host_address[0];
   assign idle_cnt_inc    = idle_cnt_q + CW'(1);

   always_comb begin
      state_d       = state_q;
      idle_cnt_d    = '0;
      cpu_hold      = 1'b1;
      host_wready   = 1'b0;
      host_rready   = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = cpu_addr;
      mem_wdata     = host_wdata;
      instr_valid_d = 1'b0;
      rrvalid_d     = 1'b0;

      case (state_q)
         S_CPU: begin
            // A host request freezes the CPU in the same cycle and suppresses
            // the fetch, so nothing but the previous fetch is in flight.
            if (host_req) begin
               state_d = S_DRAIN;
            end else begin
               cpu_hold      = 1'b0;
               mem_read      = 1'b1;
               instr_valid_d = 1'b1;
            end
         end
         S_DRAIN: begin
            state_d = S_HOST;
         end
         S_HOST: begin
            mem_address = host_addr;
            if (host_wvalid) begin
               host_wready = 1'b1;
               mem_write   = 1'b1;
            end else if (host_rvalid) begin
               host_rready = 1'b1;
               mem_read    = 1'b1;
               rrvalid_d   = 1'b1;
            end else begin
               // Count consecutive idle cycles; the last one hands over.
               idle_cnt_d = idle_cnt_inc;
               if (idle_cnt_inc == IDLE_LIM) begin
                  state_d = S_RELEASE;
               end
            end
         end
         S_RELEASE: begin
            // No access here, so no host response can still be pending when
            // the CPU resumes.  A late request goes back through DRAIN.
            state_d = host_req ? S_DRAIN : S_CPU;
         end
         default: begin
            state_d = S_CPU;
         end
      endcase

      // Keep every memory and handshake control quiet while in reset.
      if (!rst_n) begin
         state_d       = S_CPU;
         idle_cnt_d    = '0;
         cpu_hold      = 1'b0;
         host_wready   = 1'b0;
         host_rready   = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         instr_valid_d = 1'b0;
         rrvalid_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_CPU;
         idle_cnt_q    <= '0;
         instr_valid_q <= 1'b0;
         rrvalid_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         idle_cnt_q    <= idle_cnt_d;
         instr_valid_q <= instr_valid_d;
         rrvalid_q     <= rrvalid_d;
      end
   end

   assign cpu_instr       = mem_rdata;
   assign host_rdata      = mem_rdata;
   assign cpu_instr_valid = instr_valid_q;
   assign host_rrvalid    = rrvalid_q;
   assign dbg_state       = imem_arb_state_t'(state_q);

endmodule
